// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants, writeback port bundle and scan-order helper.
package core_pkg;

  localparam int XLEN    = 32;
  localparam int RA_W    = 5;
  localparam int NUM_REQ = 4;
  localparam int NUM_WP  = 2;
  localparam int PTR_W   = $clog2(NUM_REQ);

  localparam int REQ_ALU0 = 0;
  localparam int REQ_ALU1 = 1;
  localparam int REQ_MUL  = 2;
  localparam int REQ_LSU  = 3;

  typedef struct packed {
    logic            en;
    logic [RA_W-1:0] addr;
    logic [XLEN-1:0] data;
  } wp_t;

  // Position of requester idx in the rotating scan that starts at ptr.
  function automatic int scan_dist(input int idx, input int ptr);
    return (idx + NUM_REQ - ptr) % NUM_REQ;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - rotating-priority selector returning up to two one-hot grants.
module rr_pick2 #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [W-1:0] ptr,
  input  logic [N-1:0] eligible,
  output logic [N-1:0] gnt0,
  output logic [N-1:0] gnt1,
  output logic         found,
  output logic [W-1:0] last
);

  always_comb begin
    int          idx;
    logic [W-1:0] sel;
    gnt0  = '0;
    gnt1  = '0;
    found = 1'b0;
    last  = '0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      sel = W'(idx);
      if (eligible[sel]) begin
        if (!found) begin
          gnt0[sel] = 1'b1;
          found     = 1'b1;
          last      = sel;
        end else if (gnt1 == '0) begin
          gnt1[sel] = 1'b1;
          last      = sel;
        end
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares two register-file write ports among four writeback units
// and keeps the per-register busy scoreboard.
module wb_port_arbiter
  import core_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*RA_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [1:0]              iss_set_valid,
  input  logic [2*RA_W-1:0]       iss_set_rd,
  output logic [NUM_WP-1:0]       wp_en,
  output logic [NUM_WP*RA_W-1:0]  wp_addr,
  output logic [NUM_WP*XLEN-1:0]  wp_data,
  output logic [31:0]             busy
);

  logic [PTR_W-1:0]   rr_ptr;
  wp_t                wp_q [NUM_WP];
  logic [RA_W-1:0]    rd [NUM_REQ];
  logic [NUM_REQ-1:0] rd_zero;
  logic [NUM_REQ-1:0] dup;
  logic [NUM_REQ-1:0] port_elig;
  logic [NUM_REQ-1:0] gnt0;
  logic [NUM_REQ-1:0] gnt1;
  logic               any_gnt;
  logic [PTR_W-1:0]   last_gnt;
  logic [NUM_REQ-1:0] p_gnt  [NUM_WP];
  logic [RA_W-1:0]    p_addr [NUM_WP];
  logic [XLEN-1:0]    p_data [NUM_WP];
  logic [31:0]        busy_nxt;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rd[i]      = req_rd[i*RA_W +: RA_W];
      rd_zero[i] = (rd[i] == '0);
    end
  end

  // A requester loses to any earlier-in-scan valid requester targeting the same nonzero rd.
  always_comb begin
    dup = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j != i && req_valid[j] && !rd_zero[j] && rd[j] == rd[i] &&
            scan_dist(j, int'(rr_ptr)) < scan_dist(i, int'(rr_ptr)))
          dup[i] = 1'b1;
      end
    end
  end

  assign port_elig = req_valid & ~rd_zero & ~dup;

  rr_pick2 #(
    .N (NUM_REQ),
    .W (PTR_W)
  ) u_pick (
    .ptr      (rr_ptr),
    .eligible (port_elig),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .found    (any_gnt),
    .last     (last_gnt)
  );

  // rd = 0 results are accepted and dropped without taking a port.
  assign req_ready = rst ? '0 : ((req_valid & rd_zero) | gnt0 | gnt1);

  always_comb begin
    p_gnt[0] = gnt0;
    p_gnt[1] = gnt1;
    for (int p = 0; p < NUM_WP; p++) begin
      p_addr[p] = '0;
      p_data[p] = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (p_gnt[p][i]) begin
          p_addr[p] = rd[i];
          p_data[p] = req_data[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Sets are applied after clears so a new producer keeps the bit high.
  always_comb begin
    busy_nxt = busy;
    for (int p = 0; p < NUM_WP; p++) begin
      if (wp_q[p].en)
        busy_nxt[wp_q[p].addr] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      if (iss_set_valid[k])
        busy_nxt[iss_set_rd[k*RA_W +: RA_W]] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      busy   <= '0;
      for (int p = 0; p < NUM_WP; p++)
        wp_q[p] <= '0;
    end else begin
      busy <= busy_nxt;
      for (int p = 0; p < NUM_WP; p++) begin
        wp_q[p].en <= |p_gnt[p];
        if (|p_gnt[p]) begin
          wp_q[p].addr <= p_addr[p];
          wp_q[p].data <= p_data[p];
        end
      end
      if (any_gnt)
        rr_ptr <= (int'(last_gnt) == NUM_REQ - 1) ? '0 : last_gnt + PTR_W'(1);
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_WP; p++) begin
      wp_en[p]                   = wp_q[p].en;
      wp_addr[p*RA_W +: RA_W]    = wp_q[p].addr;
      wp_data[p*XLEN +: XLEN]    = wp_q[p].data;
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the register file's two write ports among four writeback requesters in the dual-issue core: ALU0, ALU1, MUL and LSU.
- Maintains the per-register busy (scoreboard) bits. Issue sets a bit; a completed write clears it.
- Sits between the functional units and the register file / register-status block.

Parameters:
- NUM_REQ, 4, number of writeback requesters; index 0 = ALU0, 1 = ALU1, 2 = MUL, 3 = LSU.
- NUM_WP, 2, number of register-file write ports. Fixed at 2 for this revision.
- XLEN, 32, data width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i holds a result.
- req_rd  in  NUM_REQ*RA_W  destination register per requester; slice i.
- req_data  in  NUM_REQ*XLEN  result data per requester; slice i.
- req_ready  out  NUM_REQ  combinational grant; a transfer occurs when valid & ready.
- iss_set_valid  in  2  issue slot k is marking a destination busy.
- iss_set_rd  in  2*RA_W  destination register per issue slot.
- wp_en  out  NUM_WP  registered write enable to the register file.
- wp_addr  out  NUM_WP*RA_W  registered write address.
- wp_data  out  NUM_WP*XLEN  registered write data.
- busy  out  32  scoreboard vector; bit r = register r has a pending producer.

Behaviour:
- Reset (asynchronous): wp_en = 0, wp_addr = 0, wp_data = 0, busy = 0, rr_ptr = 0. req_ready is 0 while rst is high.
- Arbitration is combinational and rotating-priority. Scan order is rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first two eligible valid requesters are granted; port 0 goes to the first grant, port 1 to the second.
- Eligibility rules:
  - rd = 0: always eligible. Granted without consuming a port (the result is discarded) and no busy change.
  - Same rd, same cycle: only the first requester in scan order with a given rd is granted. Later ones with the same rd wait, so no two ports ever carry the same address.
  - No stall from busy: a requester is never blocked by busy; busy only gates issue elsewhere.
- Pointer update: if at least one port-consuming grant occurs, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ. Otherwise rr_ptr holds.
- Latency: an accept at edge N drives wp_en/wp_addr/wp_data during cycle N+1. The register file writes at edge N+1.
  - Ports not granted at edge N get wp_en = 0; addr/data hold their previous values.
- Busy clear: at each edge where wp_en[p] = 1, busy[wp_addr[p]] <= 0. This coincides with the register-file write.
- Busy set: at each edge, busy[iss_set_rd[k]] <= 1 for each k with iss_set_valid[k] = 1.
- Simultaneous set and clear of the same register: set wins, because a newer producer exists.
  - Both issue slots naming the same rd: bit set once, no error.
- busy[0] is forced to 0 at all times.
- Starvation bound: every continuously-valid requester is granted within 2 cycles, since the pointer rotates past the granted requesters.
- Mid-operation reset: any pending registered write is dropped (wp_en = 0) and busy clears. Requesters must re-present after reset.
- Never at any edge: two granted ports carry the same nonzero address.

Decomposition:
- Shared package core_pkg holds:
  - XLEN, RA_W, NUM_REQ, NUM_WP;
  - requester index constants REQ_ALU0/REQ_ALU1/REQ_MUL/REQ_LSU;
  - the wp bundle typedef (en, addr, data).
- One natural sub-module: rr_pick2. A combinational rotating-priority selector that returns up to two one-hot grants plus the last-grant index, with rd-conflict masking supplied by the parent.
- The busy register and write-port flops stay in wb_port_arbiter.

Test Plan:
- Reset, then all four valid with rd = 1, 2, 3, 4 and data A0..A3 -> cycle 0 grants 0 and 1; next cycle wp_en = 2'b11, addr 1/2, data A0/A1. Cycle 1 grants 2 and 3; rr_ptr returns to 0.
- iss_set_rd = 5 at edge 0; MUL writes rd = 5 accepted at edge 3 -> busy[5] is 1 from edge 0 and falls at edge 4 with wp_en[0] = 1, addr 5.
- Edge where wp_en writes rd = 7 while iss_set_rd = 7 -> busy[7] stays 1.
- ALU0 and LSU both valid, rd = 9, rr_ptr = 0 -> only ALU0 granted; LSU granted the next cycle; wp_addr = 9 on one port only each time.
- ALU1 valid with rd = 0, MUL and LSU valid with rd = 10/11 -> all three req_ready = 1; ports carry 10 and 11; busy[0] = 0.
- Assert rst while wp_en = 2'b11 and busy = 32'h0000_0F00 -> wp_en, busy and rr_ptr are 0 immediately, without waiting for a clock edge.
